// File: rtl/sr_cpu_mlat.sv
// sr_cpu_mlat: single-cycle schoolRISCV core with a request/valid instruction fetch and a fetch watchdog.
// Define SR_CPU_MLAT_PERF_CNT_EN to build the cycleCnt/instrCnt performance counters (tied to 0 otherwise).
module sr_cpu_mlat #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imReq,
   output logic [31:0] imAddr,
   input  logic [31:0] imData,
   input  logic        imValid,
   input  logic [4:0]  regAddr,
   output logic [31:0] regData,
   output logic        fetchTimeout,
   output logic [31:0] cycleCnt,
   output logic [31:0] instrCnt
);
   // state | meaning
   // REQ   | imReq strobe for current pc, wait counter cleared
   // WAIT  | waiting for imValid, watchdog counting
   // EXEC  | execute instr_q, update pc and register file
   typedef enum logic [1:0] {REQ, WAIT, EXEC} state_t;
   typedef enum logic [2:0] {ALU_ADD, ALU_OR, ALU_SRL, ALU_SLTU, ALU_SUB} alu_t;

   localparam int              WW        = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0]   WAIT_LAST = WW'(MAX_WAIT - 1);
   localparam logic [6:0]      OP_R      = 7'b0110011;
   localparam logic [6:0]      OP_I      = 7'b0010011;
   localparam logic [6:0]      OP_LUI    = 7'b0110111;
   localparam logic [6:0]      OP_B      = 7'b1100011;
   localparam logic [6:0]      F7_SUB    = 7'b0100000;

   state_t        state;
   logic [31:0]   pc;
   logic [31:0]   instr_q;
   logic [WW-1:0] waitCnt;

   // decode
   logic [6:0]  cmdOp;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  cmdF3;
   logic [6:0]  cmdF7;
   logic [31:0] immI, immB, immU;

   assign cmdOp = instr_q[6:0];
   assign rd    = instr_q[11:7];
   assign cmdF3 = instr_q[14:12];
   assign rs1   = instr_q[19:15];
   assign rs2   = instr_q[24:20];
   assign cmdF7 = instr_q[31:25];
   assign immI  = {{20{instr_q[31]}}, instr_q[31:20]};
   assign immB  = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
   assign immU  = {instr_q[31:12], 12'b0};

   // control
   logic regWrite, aluSrc, wdSrc, branch, condZero, aluZero, pcSrc;
   alu_t aluCtrl;

   always_comb begin
      regWrite = 1'b0;
      aluSrc   = 1'b0;
      wdSrc    = 1'b0;
      branch   = 1'b0;
      condZero = 1'b0;
      aluCtrl  = ALU_ADD;
      case (cmdOp)
         OP_R: begin
            case ({cmdF7, cmdF3})
               {7'b0, 3'b000}:  begin regWrite = 1'b1; aluCtrl = ALU_ADD;  end
               {F7_SUB, 3'b000}: begin regWrite = 1'b1; aluCtrl = ALU_SUB;  end
               {7'b0, 3'b110}:  begin regWrite = 1'b1; aluCtrl = ALU_OR;   end
               {7'b0, 3'b101}:  begin regWrite = 1'b1; aluCtrl = ALU_SRL;  end
               {7'b0, 3'b011}:  begin regWrite = 1'b1; aluCtrl = ALU_SLTU; end
               default: ;
            endcase
         end
         OP_I: begin
            if (cmdF3 == 3'b000) begin
               regWrite = 1'b1;
               aluSrc   = 1'b1;
            end
         end
         OP_LUI: begin
            regWrite = 1'b1;
            wdSrc    = 1'b1;
         end
         OP_B: begin
            case (cmdF3)
               3'b000:  begin branch = 1'b1; condZero = 1'b1; aluCtrl = ALU_SUB; end
               3'b001:  begin branch = 1'b1; condZero = 1'b0; aluCtrl = ALU_SUB; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign pcSrc = branch & (aluZero == condZero);

   // register file (x0 reads zero, writes to it are dropped)
   logic [31:0] rf [0:31];
   logic [31:0] rd1, rd2, srcB, aluResult, wd;

   assign rd1     = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
   assign rd2     = (rs2 == 5'd0) ? 32'h0 : rf[rs2];
   assign regData = (regAddr == 5'd0) ? pc : rf[regAddr];

   always_ff @(posedge clk) begin
      if (!rst && state == EXEC && regWrite && rd != 5'd0)
         rf[rd] <= wd;
   end

   // alu
   assign srcB = aluSrc ? immI : rd2;

   always_comb begin
      aluResult = 32'h0;
      case (aluCtrl)
         ALU_ADD:  aluResult = rd1 + srcB;
         ALU_OR:   aluResult = rd1 | srcB;
         ALU_SRL:  aluResult = rd1 >> srcB[4:0];
         ALU_SLTU: aluResult = {31'b0, rd1 < srcB};
         ALU_SUB:  aluResult = rd1 - srcB;
         default:  aluResult = 32'h0;
      endcase
   end

   assign aluZero = (aluResult == 32'h0);
   assign wd      = wdSrc ? immU : aluResult;

   // fetch / execute sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= REQ;
         pc      <= RESET_PC;
         instr_q <= 32'h0;
         waitCnt <= '0;
      end else begin
         case (state)
            REQ: begin
               waitCnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (imValid) begin
                  instr_q <= imData;
                  state   <= EXEC;
               end else if (waitCnt == WAIT_LAST) begin
                  state   <= REQ;
               end else begin
                  waitCnt <= waitCnt + WW'(1);
               end
            end
            EXEC: begin
               pc    <= pcSrc ? pc + immB : pc + 32'd4;
               state <= REQ;
            end
            default: state <= REQ;
         endcase
      end
   end

   assign imReq        = (state == REQ);
   assign imAddr       = {2'b00, pc[31:2]};
   // a response arriving in the last WAIT cycle still wins over the watchdog
   assign fetchTimeout = (state == WAIT) && !imValid && (waitCnt == WAIT_LAST);

`ifdef SR_CPU_MLAT_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycleCnt <= 32'h0;
         instrCnt <= 32'h0;
      end else begin
         cycleCnt <= cycleCnt + 32'd1;
         if (state == EXEC)
            instrCnt <= instrCnt + 32'd1;
      end
   end
`else
   assign cycleCnt = 32'h0;
   assign instrCnt = 32'h0;
`endif

endmodule

// File: tb/tb_sr_cpu_mlat.sv
// Directed bench for sr_cpu_mlat: fetch latency, watchdog retry, branch and mid-fetch reset.
module tb_sr_cpu_mlat;
   logic        clk = 1'b0;
   logic        rst;
   logic        imReq;
   logic [31:0] imAddr;
   logic [31:0] imData;
   logic        imValid;
   logic [4:0]  regAddr;
   logic [31:0] regData;
   logic        fetchTimeout;
   logic [31:0] cycleCnt;
   logic [31:0] instrCnt;

   int nCmp = 0;
   int nBad = 0;
   logic [31:0] prog [0:15];

`ifdef SR_CPU_MLAT_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   sr_cpu_mlat #(.RESET_PC(32'h0), .MAX_WAIT(15)) dut (
      .clk(clk), .rst(rst), .imReq(imReq), .imAddr(imAddr), .imData(imData),
      .imValid(imValid), .regAddr(regAddr), .regData(regData),
      .fetchTimeout(fetchTimeout), .cycleCnt(cycleCnt), .instrCnt(instrCnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] perfExp(input logic [31:0] v);
      return PERF ? v : 32'h0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; imValid = 1'b0; imData = 32'hDEAD_BEEF; regAddr = 5'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 32'h0;
   endtask

   task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
      regAddr = a;
      #1 v = regData;
   endtask

   // starts in a REQ cycle, answers after lat cycles, ends in the next REQ cycle
   task automatic exec_one(input int lat, input string tag);
      nCmp++;
      if (imReq !== 1'b1) begin nBad++; $display("FAIL %s_imReq_req: got %b want 1", tag, imReq); end
      for (int i = 1; i <= lat; i++) begin
         tick();
         imValid = (i == lat);
         imData  = (i == lat) ? prog[imAddr[3:0]] : 32'hDEAD_BEEF;
      end
      tick();
      imValid = 1'b0; imData = 32'hDEAD_BEEF;
      nCmp++;
      if (imReq !== 1'b0) begin nBad++; $display("FAIL %s_imReq_exec: got %b want 0", tag, imReq); end
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      nCmp++; if (imReq !== 1'b1) begin nBad++; $display("FAIL rst_imReq: got %b want 1", imReq); end
      nCmp++; if (imAddr !== 32'h0) begin nBad++; $display("FAIL rst_imAddr: got %h want 0", imAddr); end
      nCmp++; if (regData !== 32'h0) begin nBad++; $display("FAIL rst_pc: got %h want 0", regData); end
      nCmp++; if (fetchTimeout !== 1'b0) begin nBad++; $display("FAIL rst_timeout: got %b want 0", fetchTimeout); end
      nCmp++; if (cycleCnt !== 32'h0) begin nBad++; $display("FAIL rst_cycleCnt: got %0d want 0", cycleCnt); end
      nCmp++; if (instrCnt !== 32'h0) begin nBad++; $display("FAIL rst_instrCnt: got %0d want 0", instrCnt); end
      tick();
      nCmp++; if (imReq !== 1'b0) begin nBad++; $display("FAIL rst_imReq_wait: got %b want 0", imReq); end
   endtask

   task automatic test_latency(input int lat, input string tag);
      logic [31:0] v;
      do_reset();
      clear_prog();
      prog[0] = 32'h0050_0093;   // addi x1,x0,5
      prog[1] = 32'h0070_0113;   // addi x2,x0,7
      prog[2] = 32'h0020_81B3;   // add  x3,x1,x2
      for (int k = 0; k < 3; k++) exec_one(lat, tag);
      nCmp++;
      if (cycleCnt !== perfExp(32'(3 * (lat + 2)))) begin
         nBad++; $display("FAIL %s_cycleCnt: got %0d want %0d", tag, cycleCnt, perfExp(32'(3 * (lat + 2))));
      end
      nCmp++;
      if (instrCnt !== perfExp(32'd3)) begin nBad++; $display("FAIL %s_instrCnt: got %0d want %0d", tag, instrCnt, perfExp(32'd3)); end
      read_reg(5'd1, v);
      nCmp++; if (v !== 32'd5) begin nBad++; $display("FAIL %s_x1: got %0d want 5", tag, v); end
      read_reg(5'd2, v);
      nCmp++; if (v !== 32'd7) begin nBad++; $display("FAIL %s_x2: got %0d want 7", tag, v); end
      read_reg(5'd3, v);
      nCmp++; if (v !== 32'd12) begin nBad++; $display("FAIL %s_x3: got %0d want 12", tag, v); end
      read_reg(5'd0, v);
      nCmp++; if (v !== 32'd12) begin nBad++; $display("FAIL %s_pc: got %0d want 12", tag, v); end
   endtask

   task automatic test_random_loop();
      logic [31:0] v;
      do_reset();
      clear_prog();
      prog[0] = 32'h0040_0093;   // addi x1,x0,4
      prog[1] = 32'hFFF0_8093;   // addi x1,x1,-1
      prog[2] = 32'hFE00_9EE3;   // bne  x1,x0,-4
      for (int k = 0; k < 9; k++) exec_one(int'($urandom_range(1, 10)), "loop");
      read_reg(5'd1, v);
      nCmp++; if (v !== 32'd0) begin nBad++; $display("FAIL loop_x1: got %0d want 0", v); end
      read_reg(5'd0, v);
      nCmp++; if (v !== 32'd12) begin nBad++; $display("FAIL loop_pc: got %0d want 12", v); end
      nCmp++; if (imAddr !== 32'd3) begin nBad++; $display("FAIL loop_imAddr: got %0d want 3", imAddr); end
      nCmp++;
      if (instrCnt !== perfExp(32'd9)) begin nBad++; $display("FAIL loop_instrCnt: got %0d want %0d", instrCnt, perfExp(32'd9)); end
   endtask

   task automatic test_timeout();
      logic [31:0] v;
      int pulses = 0;
      do_reset();
      clear_prog();
      prog[0] = 32'h02A0_0213;   // addi x4,x0,42
      for (int c = 1; c <= 20; c++) begin
         tick();
         imValid = (c == 20);
         imData  = (c == 20) ? prog[0] : 32'hDEAD_BEEF;
         #1;
         if (fetchTimeout === 1'b1) pulses++;
         if (c == 15) begin
            nCmp++; if (fetchTimeout !== 1'b1) begin nBad++; $display("FAIL to_pulse_T15: got %b want 1", fetchTimeout); end
         end
         if (c == 16) begin
            nCmp++; if (imReq !== 1'b1) begin nBad++; $display("FAIL to_reReq_T16: got %b want 1", imReq); end
            nCmp++; if (imAddr !== 32'h0) begin nBad++; $display("FAIL to_reAddr_T16: got %h want 0", imAddr); end
         end
      end
      tick();
      imValid = 1'b0; imData = 32'hDEAD_BEEF;
      tick();
      nCmp++; if (pulses != 1) begin nBad++; $display("FAIL to_pulse_count: got %0d want 1", pulses); end
      nCmp++; if (imReq !== 1'b1) begin nBad++; $display("FAIL to_next_req: got %b want 1", imReq); end
      read_reg(5'd4, v);
      nCmp++; if (v !== 32'd42) begin nBad++; $display("FAIL to_x4: got %0d want 42", v); end
      read_reg(5'd0, v);
      nCmp++; if (v !== 32'd4) begin nBad++; $display("FAIL to_pc: got %0d want 4", v); end
      nCmp++;
      if (cycleCnt !== perfExp(32'd22)) begin nBad++; $display("FAIL to_cycleCnt: got %0d want %0d", cycleCnt, perfExp(32'd22)); end
   endtask

   task automatic test_beq();
      logic [31:0] v;
      do_reset();
      clear_prog();
      prog[0] = 32'h0000_0463;   // beq x0,x0,+8
      exec_one(2, "beq");
      nCmp++; if (imAddr !== 32'd2) begin nBad++; $display("FAIL beq_imAddr: got %0d want 2", imAddr); end
      read_reg(5'd0, v);
      nCmp++; if (v !== 32'd8) begin nBad++; $display("FAIL beq_pc: got %0d want 8", v); end
   endtask

   task automatic test_reset_midwait();
      logic [31:0] v;
      do_reset();
      clear_prog();
      prog[0] = 32'h0010_0313;   // addi x6,x0,1
      exec_one(1, "rmw_pre");
      do_reset();
      prog[0] = 32'h0000_0463;   // beq x0,x0,+8
      prog[2] = 32'h0630_0313;   // addi x6,x0,99 (must never execute)
      exec_one(1, "rmw_beq");
      read_reg(5'd0, v);
      nCmp++; if (v !== 32'd8) begin nBad++; $display("FAIL rmw_pc8: got %0d want 8", v); end
      tick();
      imValid = 1'b0;
      tick();
      imValid = 1'b1; imData = prog[2]; rst = 1'b1;
      tick();
      rst = 1'b0; imValid = 1'b0; imData = 32'hDEAD_BEEF;
      read_reg(5'd0, v);
      nCmp++; if (v !== 32'h0) begin nBad++; $display("FAIL rmw_pc_reset: got %h want 0", v); end
      nCmp++; if (imReq !== 1'b1) begin nBad++; $display("FAIL rmw_imReq: got %b want 1", imReq); end
      nCmp++; if (cycleCnt !== 32'h0) begin nBad++; $display("FAIL rmw_cycleCnt: got %0d want 0", cycleCnt); end
      nCmp++; if (instrCnt !== 32'h0) begin nBad++; $display("FAIL rmw_instrCnt: got %0d want 0", instrCnt); end
      read_reg(5'd6, v);
      nCmp++; if (v !== 32'd1) begin nBad++; $display("FAIL rmw_x6_stale: got %0d want 1", v); end
      exec_one(1, "rmw_post");
      read_reg(5'd0, v);
      nCmp++; if (v !== 32'd8) begin nBad++; $display("FAIL rmw_post_pc: got %0d want 8", v); end
      read_reg(5'd6, v);
      nCmp++; if (v !== 32'd1) begin nBad++; $display("FAIL rmw_post_x6: got %0d want 1", v); end
   endtask

   initial begin
      test_reset();
      test_latency(6, "lat6");
      test_latency(1, "lat1");
      test_random_loop();
      test_timeout();
      test_beq();
      test_reset_midwait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule

// File: doc/sr_cpu_mlat.md
# sr_cpu_mlat

Single-cycle schoolRISCV core (`sr_decode`, `sr_register_file`, `sr_alu`, `sr_control` reused unchanged) with a request/valid instruction-fetch front end.
- Tolerates any instruction-memory latency of one cycle or more, fixed or variable.
- Has a fetch watchdog that re-issues a fetch request when memory does not answer.
- Replaces the fixed two-state fetch/proc sequencer of the previous core.
- Sits between the testbench/SoC instruction memory and the debug register port.

## Interface
- `RESET_PC`, 32'h0: byte address loaded into pc on reset.
- `MAX_WAIT`, 15: WAIT cycles without `imValid` before a retry; legal range 1..255.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `imReq`  out  1  fetch request strobe, one cycle per request.
- `imAddr`  out  32  word address, `pc >> 2`; stable from REQ through EXEC.
- `imData`  in  32  instruction word; sampled only when `imValid` is high in WAIT.
- `imValid`  in  1  `imData` is valid this cycle.
- `regAddr`  in  5  debug register index.
- `regData`  out  32  value of `x[regAddr]`; returns pc when `regAddr == 0`.
- `fetchTimeout`  out  1  one-cycle pulse when the watchdog fires.
- `cycleCnt`  out  32  cycles since reset; see Configuration.
- `instrCnt`  out  32  retired instructions; see Configuration.

## Operation
- FSM states: REQ, WAIT, EXEC. Reset state is REQ.
- REQ:
  - `imReq = 1`.
  - Wait counter cleared.
  - Next state is WAIT.
- WAIT:
  - If `imValid` is high: `imData` is latched into `instr_q` and the next state is EXEC.
  - Else, if the wait counter equals `MAX_WAIT - 1`: `fetchTimeout` pulses and the next state is REQ, re-requesting the same pc.
  - Else: the wait counter increments.
- EXEC:
  - Decode and execute `instr_q`.
  - Register file write enable = `regWrite`; writes to x0 are discarded by the register file.
  - pc loads `pcSrc ? pc + immB : pc + 4`.
  - `instrCnt` increments.
  - Next state is REQ.
- pc and the register file change only in EXEC; they are frozen in REQ and WAIT.
- `imValid` is ignored in REQ and EXEC. Late responses from a timed-out request are dropped unless they arrive in a WAIT cycle; the bench must not issue them.
- The decoder is always driven from `instr_q`, never from `imData` combinationally.
- Arithmetic:
  - pc arithmetic is modulo 2^32.
  - The wait counter width is `$clog2(MAX_WAIT+1)`.
  - Counters wrap at 2^32 with no saturation.
- Supported ops are those of `sr_control`: add, or, srl, sltu, sub, addi, lui, beq, bne. Unknown opcodes execute as a no-op: no write, pc + 4.

## Timing
- Reset values:
  - state = REQ, pc = `RESET_PC`, `instr_q` = 0, wait counter = 0.
  - `imReq` = 1 in the first cycle after reset release.
  - `fetchTimeout` = 0, `cycleCnt` = 0, `instrCnt` = 0.
  - Register file contents are not reset.
- Memory latency L is counted from the REQ cycle T: `imValid` arrives at T+L, with L ≥ 1.
- EXEC occurs at T+L+1, so one instruction costs L+2 cycles.
- The register write and the new pc are visible on `regData` one cycle after EXEC.
- Watchdog:
  - With no valid response, `fetchTimeout` pulses at cycle T+`MAX_WAIT`.
  - The next REQ is at T+`MAX_WAIT`+1.
- Reset asserted in any state (including mid-WAIT or EXEC) takes effect at that clock edge:
  - The pending fetch is abandoned.
  - No register write or pc update occurs in that cycle.

## Configuration
- Macro: `SR_CPU_MLAT_PERF_CNT_EN`.
- Defined:
  - `cycleCnt` increments every cycle not in reset.
  - `instrCnt` increments in every EXEC.
- Undefined:
  - Both counters are removed and the ports are tied to 32'h0.
  - All other behaviour is identical.

## Test plan
- Fixed latency L=1, program `addi x1,x0,5; addi x2,x0,7; add x3,x1,x2`:
  - x3 = 12.
  - EXEC every 3 cycles.
  - `instrCnt` = 3 after the third EXEC.
- Same program with L=6:
  - Identical register results.
  - 8 cycles per instruction.
  - `cycleCnt` = 24 at the third EXEC+1.
- Random latency 1..10 per fetch, running a countdown loop (`addi x1,x0,4`; loop `addi x1,x1,-1; bne x1,x0,loop`):
  - Ends with x1 = 0.
  - pc = 12.
  - `instrCnt` = 9.
- Memory withholds `imValid` for 20 cycles with `MAX_WAIT` = 15:
  - `fetchTimeout` pulses exactly once at T+15.
  - `imReq` re-asserts at T+16 with the same `imAddr`.
  - The instruction then executes normally.
- beq taken, `beq x0,x0,+8` at pc 0:
  - Next `imAddr` = 2.
  - pc = 8 on `regData` with `regAddr` = 0.
- `rst` asserted mid-WAIT after pc reached 8:
  - Next cycle: pc = `RESET_PC`, `imReq` = 1, counters 0.
  - No stale `imData` is executed.
